// File: rtl/spike_event_sched.sv
// spike_event_sched: turns spike edges into timestamped events and sequences them with step requests onto the FP64 datapath
module spike_event_sched #(
    parameter int STEP_CYCLES = 50,
    parameter int FIFO_DEPTH  = 4,
    parameter int TS_W        = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        tp1,
    input  logic                        td4,
    input  logic                        dp_done,
    output logic                        op_start,
    output logic [1:0]                  op_code,
    output logic [TS_W-1:0]             op_dt,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  drop_cnt,
    output logic                        step_miss
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_PRE  = 2'b01;
    localparam logic [1:0] OP_POST = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic            tp1_q, td4_q, pre_ev, post_ev, tick;
    logic            push_pre, push_post, grant_step, grant_spike, last_spike, step_pend;
    logic [TS_W-1:0] age_pre, age_post, pre_dt, post_dt;
    logic [TS_W+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     free;
    logic [1:0]      n_drop;
    logic [8:0]      drop_sum;
    logic [SW-1:0]   step_cnt;

    assign pre_ev    = tp1 & ~tp1_q & enable;
    assign post_ev   = td4 & ~td4_q & enable;
    assign tick      = enable && step_cnt == 0;
    assign pre_dt    = age_post;
    assign post_dt   = pre_ev ? '0 : age_pre;
    assign free      = (AW+1)'(FIFO_DEPTH) - fifo_count;
    // a lone free slot goes to the pre event, so post needs one more than pre consumed
    assign push_pre  = pre_ev && free != 0;
    assign push_post = post_ev && free > (AW+1)'(push_pre);
    assign n_drop    = {1'b0, pre_ev & ~push_pre} + {1'b0, post_ev & ~push_post};
    assign drop_sum  = {1'b0, drop_cnt} + {7'b0, n_drop};
    // on contention the requester opposite to the previous grant wins
    assign grant_step  = state == IDLE && step_pend && (fifo_count == 0 || last_spike);
    assign grant_spike = state == IDLE && fifo_count != 0 && (!step_pend || !last_spike);

    always_ff @(posedge clk) begin
        if (push_pre) mem[wr_ptr] <= {OP_PRE, pre_dt};
        if (push_post) mem[wr_ptr + AW'(push_pre)] <= {OP_POST, post_dt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tp1_q      <= 1'b0;
            td4_q      <= 1'b0;
            age_pre    <= '1;
            age_post   <= '1;
            step_cnt   <= SW'(STEP_CYCLES - 1);
            step_pend  <= 1'b0;
            step_miss  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_cnt   <= '0;
            last_spike <= 1'b1;
            state      <= IDLE;
            op_start   <= 1'b0;
            op_code    <= OP_STEP;
            op_dt      <= '0;
            busy       <= 1'b0;
        end else begin
            tp1_q <= tp1;
            td4_q <= td4;
            if (enable) begin
                age_pre  <= pre_ev ? '0 : age_pre + TS_W'(~&age_pre);
                age_post <= post_ev ? '0 : age_post + TS_W'(~&age_post);
                step_cnt <= step_cnt == 0 ? SW'(STEP_CYCLES - 1) : step_cnt - SW'(1);
            end
            if (tick && step_pend) step_miss <= 1'b1;
            step_pend  <= tick | (step_pend & ~grant_step);
            wr_ptr     <= wr_ptr + AW'(push_pre) + AW'(push_post);
            rd_ptr     <= rd_ptr + AW'(grant_spike);
            fifo_count <= fifo_count + (AW+1)'(push_pre) + (AW+1)'(push_post) - (AW+1)'(grant_spike);
            drop_cnt   <= drop_sum[8] ? 8'hff : drop_sum[7:0];
            op_start   <= 1'b0;
            case (state)
                IDLE: if (grant_step || grant_spike) begin
                    state      <= ISSUE;
                    op_start   <= 1'b1;
                    busy       <= 1'b1;
                    last_spike <= grant_spike;
                    {op_code, op_dt} <= grant_spike ? mem[rd_ptr] : {OP_STEP, TS_W'(0)};
                end
                ISSUE: state <= WAIT;
                WAIT: if (dp_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
